// File: rtl/l2_pmem_pkg.sv
// Shared types and constants for the L2 physical-memory burst responder.
package l2_pmem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } pmem_state_t;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_OFFSET_BITS = 3;

    typedef logic [255:0] line_t;

endpackage

// File: rtl/l2_line_beat_buffer.sv
// Line storage for the burst responder: a read line assembled one beat at a
// time and a write line latched whole, with the beat select picking the
// outgoing write slice.
module l2_line_beat_buffer
    import l2_pmem_pkg::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    localparam int IDX_W     = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_load_i,
    input  line_t                 wr_line_i,
    input  logic                  rd_beat_we_i,
    input  logic [IDX_W-1:0]      beat_sel_i,
    input  logic [BEAT_WIDTH-1:0] rd_beat_i,
    output line_t                 rd_line_o,
    output logic [BEAT_WIDTH-1:0] wr_slice_o
);

    line_t rd_line_q;
    line_t wr_line_q;

    // Read line only changes on a captured read beat; write line only on a new write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_line_q <= '0;
            wr_line_q <= '0;
        end else begin
            if (wr_load_i) begin
                wr_line_q <= wr_line_i;
            end
            if (rd_beat_we_i) begin
                rd_line_q[beat_sel_i*BEAT_WIDTH +: BEAT_WIDTH] <= rd_beat_i;
            end
        end
    end

    assign rd_line_o  = rd_line_q;
    assign wr_slice_o = wr_line_q[beat_sel_i*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/l2_pmem_burst_responder.sv
// L2 physical-memory port responder: turns one line read/write into a burst
// of narrower beats on the backing-memory interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a line request; write has priority over read
// RD_BURST | issuing beat reads, capturing each returned beat
// WR_BURST | issuing beat writes from the latched line
// RESP     | one-cycle pmem_resp; requests deliberately not sampled here
module l2_pmem_burst_responder
    import l2_pmem_pkg::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  line_t                 pmem_wdata,
    output line_t                 pmem_rdata,
    output logic                  pmem_resp,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [ADDR_WIDTH-1:0] bmem_address,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int BASE_W     = ADDR_WIDTH - LINE_OFFSET_BITS;

    pmem_state_t           state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic                  wr_load;
    logic                  rd_beat_we;
    logic                  last_beat;

    // The line offset bits of the request address are meaningless here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^pmem_address[LINE_OFFSET_BITS-1:0];

    assign last_beat = (beat_q == BEAT_IDX_W'(BEATS - 1));

    // State, beat counter and latched line base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    // Next-state and request/response generation.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        wr_load    = 1'b0;
        rd_beat_we = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    base_d  = pmem_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
                    beat_d  = '0;
                    wr_load = 1'b1;
                    state_d = WR_BURST;
                end else if (pmem_read) begin
                    base_d  = pmem_address[ADDR_WIDTH-1:LINE_OFFSET_BITS];
                    beat_d  = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                bmem_read = 1'b1;
                if (bmem_resp) begin
                    rd_beat_we = 1'b1;
                    beat_d     = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                if (bmem_resp) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                pmem_resp = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bmem_address = {base_q, beat_q, {BEAT_OFFSET_BITS{1'b0}}};

    l2_line_beat_buffer #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (BEATS)
    ) u_line_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_load_i    (wr_load),
        .wr_line_i    (pmem_wdata),
        .rd_beat_we_i (rd_beat_we),
        .beat_sel_i   (beat_q),
        .rd_beat_i    (bmem_rdata),
        .rd_line_o    (pmem_rdata),
        .wr_slice_o   (bmem_wdata)
    );

endmodule
